// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   state_t   : responder FSM states (IDLE, BUSY, RESP)
//   WORD_OFF  : byte-address bits below the word index
//   BE_W      : byte-enable width
//   addr_bad  : misaligned or out-of-range address check
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned WORD_OFF = 2;
    localparam int unsigned BE_W     = 4;

    // Misaligned, or any bit set above the RAM's word-index range.
    function automatic logic addr_bad(input logic [31:0] addr, input int unsigned aw);
        return (addr[WORD_OFF-1:0] != '0) || ((addr >> (aw + WORD_OFF)) != 32'd0);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word RAM with per-byte write mask and registered read.
//   clk   : clock
//   en    : access enable (read when we=0, write when we=1)
//   we    : write enable
//   be    : byte enables for writes (byte i = bits 8i+7:8i)
//   addr  : word index
//   wdata : write data
//   rdata : registered read data, updated only by reads
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [BE_W-1:0]       be,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] wmask;

    // Expand byte enables to a bit mask; lanes beyond BE_W always write.
    always_comb begin
        wmask = '0;
        for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            if ((i / 8) < int'(BE_W)) begin
                wmask[i] = be[i/8];
            end else begin
                wmask[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= (mem[addr] & ~wmask) | (wdata & wmask);
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-stage data-memory responder: accepts one load/store at a time, waits
// WAIT_STATES cycles, performs the RAM access and emits a one-cycle response.
//   clk, rst    : clock, asynchronous active-high reset
//   req_valid   : request present
//   req_ready   : high only in IDLE
//   req_write   : 1 = store, 0 = load
//   req_addr    : byte address
//   req_wdata   : store data
//   req_be      : byte enables (present only with DMEM_BYTE_MASK_EN)
//   resp_valid  : one-cycle response strobe
//   resp_rdata  : load data; 0 for stores and errors
//   resp_error  : misaligned or out-of-range address
//   active      : request outstanding (BUSY or RESP)
// Build option: define DMEM_BYTE_MASK_EN for byte-masked stores.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
`ifdef DMEM_BYTE_MASK_EN
    input  logic [BE_W-1:0]       req_be,
`endif
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_error,
    output logic                  active
);

    localparam int unsigned CNT_W = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic                  wr_q;
    logic [31:0]           addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [BE_W-1:0]       be_q;
    logic                  load_q;

    logic [BE_W-1:0]       be_in;
    logic                  acc_write;
    logic [31:0]           acc_addr;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic [BE_W-1:0]       acc_be;
    logic                  acc_err;
    logic                  go_resp;
    logic                  mem_en;
    logic [DATA_WIDTH-1:0] mem_rdata;

`ifdef DMEM_BYTE_MASK_EN
    assign be_in = req_be;
`else
    assign be_in = '1;
`endif

    // Access operands: live request inputs when going straight from IDLE to
    // RESP (zero wait states), otherwise the latched request.
    always_comb begin
        acc_write = wr_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_be    = be_q;
        go_resp   = 1'b0;
        unique case (state)
            IDLE: begin
                acc_write = req_write;
                acc_addr  = req_addr;
                acc_wdata = req_wdata;
                acc_be    = be_in;
                go_resp   = req_valid && (WAIT_STATES == 0);
            end
            BUSY:    go_resp = (cnt == CNT_W'(1));
            default: go_resp = 1'b0;
        endcase
    end

    assign acc_err = addr_bad(acc_addr, ADDR_WIDTH);
    assign mem_en  = go_resp && !acc_err;

    // RAM access happens on the edge that enters RESP.
    dmem_array #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_array (
        .clk  (clk),
        .en   (mem_en),
        .we   (acc_write),
        .be   (acc_be),
        .addr (acc_addr[ADDR_WIDTH+WORD_OFF-1:WORD_OFF]),
        .wdata(acc_wdata),
        .rdata(mem_rdata)
    );

    // Read data is only exposed for a successful load; held until next RESP.
    assign resp_rdata = load_q ? mem_rdata : '0;

    // Responder FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            load_q     <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            active     <= 1'b0;
        end else begin
            resp_valid <= go_resp;
            if (go_resp) begin
                resp_error <= acc_err;
                load_q     <= !acc_write && !acc_err;
            end
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        wr_q      <= req_write;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        be_q      <= be_in;
                        cnt       <= CNT_W'(WAIT_STATES);
                        req_ready <= 1'b0;
                        active    <= 1'b1;
                        state     <= go_resp ? RESP : BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt - CNT_W'(1);
                    if (go_resp) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    active    <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    active    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with two wait states,
// one with zero wait states.
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // Instance A: WAIT_STATES = 2
    logic        a_valid, a_write, a_ready, a_rvalid, a_err, a_active;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [3:0]  a_be;

    // Instance B: WAIT_STATES = 0
    logic        b_valid, b_write, b_ready, b_rvalid, b_err, b_active;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [3:0]  b_be;

    int total = 0;
    int bad   = 0;

    data_mem_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_STATES(2)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .req_valid (a_valid),
        .req_ready (a_ready),
        .req_write (a_write),
        .req_addr  (a_addr),
        .req_wdata (a_wdata),
`ifdef DMEM_BYTE_MASK_EN
        .req_be    (a_be),
`endif
        .resp_valid(a_rvalid),
        .resp_rdata(a_rdata),
        .resp_error(a_err),
        .active    (a_active)
    );

    data_mem_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_STATES(0)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .req_valid (b_valid),
        .req_ready (b_ready),
        .req_write (b_write),
        .req_addr  (b_addr),
        .req_wdata (b_wdata),
`ifdef DMEM_BYTE_MASK_EN
        .req_be    (b_be),
`endif
        .resp_valid(b_rvalid),
        .resp_rdata(b_rdata),
        .resp_error(b_err),
        .active    (b_active)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One request on instance A; returns response data, error and latency
    // in cycles after the accept edge (0 if no response within the budget).
    task automatic a_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, output logic [31:0] rd, output logic er,
                         output int lat);
        @(negedge clk);
        a_valid = 1'b1;
        a_write = wr;
        a_addr  = addr;
        a_wdata = wd;
        a_be    = be;
        chk("a_ready_idle", 64'(a_ready), 64'(1));
        @(posedge clk);
        #1 a_valid = 1'b0;
        lat = 0;
        rd  = '0;
        er  = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (a_rvalid) begin
                lat = c;
                rd  = a_rdata;
                er  = a_err;
                break;
            end
        end
        @(negedge clk);
        chk("a_rvalid_one_cycle", 64'(a_rvalid), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [5:0]  rdy_pat, rv_pat;
        logic        seen;

        rst     = 1'b1;
        a_valid = 1'b0; a_write = 1'b0; a_addr = '0; a_wdata = '0; a_be = 4'hF;
        b_valid = 1'b0; b_write = 1'b0; b_addr = '0; b_wdata = '0; b_be = 4'hF;

        repeat (2) @(negedge clk);
        chk("rst_ready",  64'(a_ready),  64'(1));
        chk("rst_rvalid", 64'(a_rvalid), 64'(0));
        chk("rst_rdata",  64'(a_rdata),  64'(0));
        chk("rst_error",  64'(a_err),    64'(0));
        chk("rst_active", 64'(a_active), 64'(0));
        rst = 1'b0;

        // Store then load with two wait states
        a_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
        chk("st10_lat",   64'(lat), 64'(3));
        chk("st10_err",   64'(er),  64'(0));
        chk("st10_rdata", 64'(rd),  64'(0));
        a_txn(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
        chk("ld10_lat",   64'(lat), 64'(3));
        chk("ld10_rdata", 64'(rd),  64'hDEADBEEF);
        chk("ld10_err",   64'(er),  64'(0));

        // Misaligned load
        a_txn(1'b0, 32'h13, 32'h0, 4'hF, rd, er, lat);
        chk("ld13_err",   64'(er), 64'(1));
        chk("ld13_rdata", 64'(rd), 64'(0));

        // Out-of-range stores alias word 0 if wrongly written
        a_txn(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rd, er, lat);
        a_txn(1'b1, 32'h1002, 32'h12345678, 4'hF, rd, er, lat);
        chk("st1002_err", 64'(er), 64'(1));
        a_txn(1'b1, 32'h1000, 32'h55555555, 4'hF, rd, er, lat);
        chk("st1000_err",   64'(er), 64'(1));
        chk("st1000_rdata", 64'(rd), 64'(0));
        a_txn(1'b0, 32'h0, 32'h0, 4'hF, rd, er, lat);
        chk("ld0_unchanged", 64'(rd), 64'hCAFEF00D);
        chk("ld0_err",       64'(er), 64'(0));

        // req_valid during BUSY with a different address is ignored
        a_txn(1'b1, 32'h44, 32'h33333333, 4'hF, rd, er, lat);
        @(negedge clk);
        a_valid = 1'b1; a_write = 1'b1; a_addr = 32'h40; a_wdata = 32'h11111111;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("busy_ready",  64'(a_ready),  64'(0));
        chk("busy_active", 64'(a_active), 64'(1));
        a_addr = 32'h44; a_wdata = 32'h22222222;
        @(negedge clk);
        chk("busy_no_resp", 64'(a_rvalid), 64'(0));
        a_valid = 1'b0;
        @(negedge clk);
        chk("busy_resp", 64'(a_rvalid), 64'(1));
        chk("busy_err",  64'(a_err),    64'(0));
        a_txn(1'b0, 32'h40, 32'h0, 4'hF, rd, er, lat);
        chk("ld40", 64'(rd), 64'h11111111);
        a_txn(1'b0, 32'h44, 32'h0, 4'hF, rd, er, lat);
        chk("ld44", 64'(rd), 64'h33333333);

        // Reset during BUSY drops the store
        a_txn(1'b1, 32'h20, 32'hA5A5A5A5, 4'hF, rd, er, lat);
        @(negedge clk);
        a_valid = 1'b1; a_write = 1'b1; a_addr = 32'h20; a_wdata = 32'h5A5A5A5A;
        @(posedge clk);
        #1 a_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_active", 64'(a_active), 64'(1));
        rst = 1'b1;
        #1;
        chk("async_rst_active", 64'(a_active), 64'(0));
        chk("async_rst_ready",  64'(a_ready),  64'(1));
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | a_rvalid;
        end
        chk("rst_no_resp", 64'(seen), 64'(0));
        a_txn(1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
        chk("ld20_prior", 64'(rd), 64'hA5A5A5A5);

        // Zero wait states, request held valid: accepts every 2 cycles
        @(negedge clk);
        b_valid = 1'b1; b_write = 1'b1; b_addr = 32'h8; b_wdata = 32'h01020304;
        rdy_pat = '0;
        rv_pat  = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            rdy_pat[k] = b_ready;
            rv_pat[k]  = b_rvalid;
        end
        chk("ws0_ready_pattern",  64'(rdy_pat), 64'(6'b101010));
        chk("ws0_rvalid_pattern", 64'(rv_pat),  64'(6'b010101));
        b_write = 1'b0;
        @(negedge clk);
        chk("ws0_ld_rvalid", 64'(b_rvalid), 64'(1));
        chk("ws0_ld_rdata",  64'(b_rdata),  64'h01020304);
        chk("ws0_ld_err",    64'(b_err),    64'(0));
        b_valid = 1'b0;

`ifdef DMEM_BYTE_MASK_EN
        a_txn(1'b1, 32'h50, 32'h11223344, 4'hF, rd, er, lat);
        a_txn(1'b1, 32'h50, 32'hAABBCCDD, 4'b0101, rd, er, lat);
        a_txn(1'b1, 32'h50, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
        chk("be0_lat", 64'(lat), 64'(3));
        chk("be0_err", 64'(er),  64'(0));
        a_txn(1'b0, 32'h50, 32'h0, 4'hF, rd, er, lat);
        chk("be_merge", 64'(rd), 64'h11BB33DD);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
